fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage LEGv8 pipeline, directly upstream of the decode stage and the hazard detection unit. It owns the PC register, issues requests to instruction memory over a ready-based handshake, and owns the IF/ID pipeline register. It obeys the hazard unit's `stall` by freezing IF/ID and buffering any fetched word, and obeys branch redirects by flushing IF/ID and discarding wrong-path fetches.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, the ready-based imem request and the IF/ID register.
// A stalled fetch is parked in a one-word buffer; a redirect during a pending fetch drains the stale request.
module fetch_stage #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   PC_RESET = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          PCSrc,
    input  logic [N-1:0]  PCBranch,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    output logic [N-1:0]  ID_pc,
    output logic [31:0]   ID_instr,
    output logic          ID_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   drain_addr_q, drain_addr_d;
    logic [31:0]    buf_instr_q, buf_instr_d;
    logic [N-1:0]   id_pc_q, id_pc_d;
    logic [31:0]    id_instr_q, id_instr_d;
    logic           id_valid_q, id_valid_d;
    logic [N-1:0]   pc_inc_s;

    assign pc_inc_s = pc_q + {{(N-3){1'b0}}, 3'b100};

    // Next-state and IF/ID update for every state / input combination
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        case (state_q)
            FETCH: begin
                if (PCSrc) begin
                    pc_d       = PCBranch;
                    id_instr_d = 32'd0;
                    id_valid_d = 1'b0;
                    if (imem_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        id_pc_d    = pc_q;
                        id_instr_d = imem_rdata;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc_s;
                    end
                end else if (!stall) begin
                    id_instr_d = 32'd0;
                    id_valid_d = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    buf_instr_d = 32'd0;
                    pc_d        = PCBranch;
                    id_instr_d  = 32'd0;
                    id_valid_d  = 1'b0;
                    state_d     = FETCH;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    id_pc_d    = pc_q;
                    id_instr_d = buf_instr_q;
                    id_valid_d = 1'b1;
                    pc_d       = pc_inc_s;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                // IF/ID is already a bubble on entry; it stays one until the drain ends
                if (PCSrc || !stall) begin
                    id_instr_d = 32'd0;
                    id_valid_d = 1'b0;
                end else begin
                    id_valid_d = id_valid_q;
                end
                if (PCSrc) begin
                    pc_d = PCBranch;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC, buffer and IF/ID registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= PC_RESET;
            drain_addr_q <= '0;
            buf_instr_q  <= 32'd0;
            id_pc_q      <= '0;
            id_instr_q   <= 32'd0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign imem_req  = ~reset & (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign ID_pc     = id_pc_q;
    assign ID_instr  = id_instr_q;
    assign ID_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/latency traffic,
// all checked cycle by cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        PCSrc;
    logic [63:0] PCBranch;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;

    int tests = 0;
    int fails = 0;

    // Model: program counter, a queue holding at most one parked word,
    // and a flag/address for a stale request still on the bus.
    logic [63:0] m_pc;
    logic [31:0] m_park[$];
    bit          m_stale;
    logic [63:0] m_stale_addr;
    logic [63:0] m_id_pc;
    logic [31:0] m_id_instr;
    bit          m_id_valid;

    fetch_stage #(.N(64), .PC_RESET(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .PCBranch(PCBranch),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ID_pc(ID_pc), .ID_instr(ID_instr), .ID_valid(ID_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] | 32'hAA00_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0;
        m_park.delete();
        m_stale = 1'b0;
        m_stale_addr = 64'h0;
        m_id_pc = 64'h0;
        m_id_instr = 32'h0;
        m_id_valid = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit br, input logic [63:0] tgt,
                              input bit rdy, input logic [31:0] word);
        if (m_stale) begin
            if (br || !s) begin m_id_valid = 1'b0; m_id_instr = 32'h0; end
            if (br) m_pc = tgt;
            if (rdy) m_stale = 1'b0;
        end else if (m_park.size() != 0) begin
            if (br) begin
                m_park.delete();
                m_pc = tgt; m_id_valid = 1'b0; m_id_instr = 32'h0;
            end else if (!s) begin
                m_id_pc = m_pc; m_id_instr = m_park.pop_front(); m_id_valid = 1'b1;
                m_pc = m_pc + 64'd4;
            end
        end else begin
            if (br) begin
                m_id_valid = 1'b0; m_id_instr = 32'h0;
                if (!rdy) begin m_stale = 1'b1; m_stale_addr = m_pc; end
                m_pc = tgt;
            end else if (rdy) begin
                if (s) m_park.push_back(word);
                else begin
                    m_id_pc = m_pc; m_id_instr = word; m_id_valid = 1'b1;
                    m_pc = m_pc + 64'd4;
                end
            end else if (!s) begin
                m_id_valid = 1'b0; m_id_instr = 32'h0;
            end
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit s, input bit br, input logic [63:0] tgt, input bit rdy);
        logic [63:0] exp_addr;
        logic [31:0] word;
        exp_addr   = m_stale ? m_stale_addr : m_pc;
        word       = rdy ? mem_word(exp_addr) : $urandom;
        stall      = s;
        PCSrc      = br;
        PCBranch   = tgt;
        imem_ready = rdy;
        imem_rdata = word;
        #3;
        chk("imem_req", {63'd0, imem_req}, {63'd0, (m_park.size() == 0)});
        chk("imem_addr", imem_addr, exp_addr);
        @(posedge clk);
        model_edge(s, br, tgt, rdy, word);
        #1;
        chk("ID_valid", {63'd0, ID_valid}, {63'd0, m_id_valid});
        chk("ID_instr", {32'd0, ID_instr}, {32'd0, m_id_instr});
        if (m_id_valid) chk("ID_pc", ID_pc, m_id_pc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; PCBranch = 64'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, ID_valid}, 64'd0);
        chk("rst_pc", ID_pc, 64'h0);
        chk("rst_instr", {32'd0, ID_instr}, 64'h0);
        reset = 1'b0;

        // Zero-wait streaming from PC_RESET
        cycle(0, 0, 64'h0, 1); chk("seq0", ID_pc, 64'h0);
        cycle(0, 0, 64'h0, 1); chk("seq1", ID_pc, 64'h4);
        cycle(0, 0, 64'h0, 1); chk("seq2", ID_pc, 64'h8);

        // Two-cycle stall, then release with no skip or duplicate
        cycle(1, 0, 64'h0, 1); chk("stall_hold1", ID_pc, 64'h8);
        cycle(1, 0, 64'h0, 1); chk("stall_hold2", ID_pc, 64'h8);
        chk("hold_req", {63'd0, imem_req}, 64'd0);
        cycle(0, 0, 64'h0, 1); chk("stall_rel", ID_pc, 64'hC);
        chk("stall_rel_instr", {32'd0, ID_instr}, {32'd0, 32'hAA00_000C});

        // Redirect while parked in HOLD with stall still high
        cycle(1, 0, 64'h0, 1);
        cycle(1, 1, 64'h40, 1);
        chk("hold_br_valid", {63'd0, ID_valid}, 64'd0);
        chk("hold_br_addr", imem_addr, 64'h40);
        cycle(0, 0, 64'h0, 1); chk("hold_br_tgt", ID_pc, 64'h40);

        // Redirect during a slow fetch of 0x10: stale request drained
        cycle(0, 1, 64'h10, 1);
        cycle(0, 0, 64'h0, 0);
        cycle(0, 1, 64'h80, 0); chk("drain_addr", imem_addr, 64'h10);
        cycle(0, 0, 64'h0, 0); chk("drain_addr2", imem_addr, 64'h10);
        cycle(0, 0, 64'h0, 1); chk("drain_done", imem_addr, 64'h80);
        chk("drain_bubble", {63'd0, ID_valid}, 64'd0);
        cycle(0, 0, 64'h0, 1); chk("drain_tgt", ID_pc, 64'h80);

        // PC wrap-around
        cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        cycle(0, 0, 64'h0, 1);
        chk("wrap_id", ID_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc", imem_addr, 64'h0);

        // Asynchronous reset in the middle of a drain
        cycle(0, 1, 64'h20, 1);
        cycle(0, 1, 64'h30, 0); chk("pre_rst_drain", imem_addr, 64'h20);
        reset = 1'b1;
        #1;
        chk("arst_req", {63'd0, imem_req}, 64'd0);
        chk("arst_addr", imem_addr, 64'h0);
        chk("arst_valid", {63'd0, ID_valid}, 64'd0);
        chk("arst_pc", ID_pc, 64'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(0, 0, 64'h0, 1); chk("arst_restart", ID_pc, 64'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt;
            tgt = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), tgt,
                  ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
